if_stage_regs: RTL and testbench

- Fetch-side responder to the pipeline's load-use hazard unit. Owns the program counter and the IF/ID pipeline register, and obeys the PCwrite / IF_IDwrite stall requests.
- Applies branch/jump redirects from EX as a flush of IF/ID.
- Provides stall and flush event counters for debug and performance.
- Sits between instruction memory (combinational read) and the ID stage.

---
 rtl/if_stage_regs_pkg.sv | 35 +++
 rtl/if_stage_regs_pc_reg.sv | 41 ++++
 rtl/if_stage_regs.sv | 83 ++++++++
 tb/tb_if_stage_regs.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/if_stage_regs_pkg.sv
`default_nettype none
//============================================================================
// Module   : if_stage_regs_pkg
// Desc     : Shared pipeline constants and types for the fetch stage and the
//            ID/EX bubble insertion logic.
// Revision : 1.0 - initial release
//============================================================================
package if_stage_regs_pkg;

    localparam int XLEN = 32;

    // addi x0,x0,0 -- the canonical bubble encoding for every pipeline stage
    localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [XLEN-1:0] PC_STEP          = 32'd4;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
        logic            valid;
    } if_id_t;

    localparam if_id_t IF_ID_BUBBLE = '{pc: '0, instr: NOP_INSTR, valid: 1'b0};

    function automatic if_id_t make_if_id(input logic [XLEN-1:0] pc,
                                          input logic [XLEN-1:0] instr);
        if_id_t r;
        r.pc    = pc;
        r.instr = instr;
        r.valid = 1'b1;
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/if_stage_regs_pc_reg.sv
`default_nettype none
//============================================================================
// Module   : if_stage_regs_pc_reg
// Desc     : Program counter register: reset > redirect > hold > +4 advance.
// Revision : 1.0 - initial release
//============================================================================
module if_stage_regs_pc_reg
    import if_stage_regs_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_redirect,
    input  logic [XLEN-1:0] i_target,
    input  logic            i_advance,
    output logic [XLEN-1:0] o_pc
);

    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] w_target_aligned;
    logic            w_unused_target_lsbs;

    // Instructions are word aligned; the low target bits carry no information.
    assign w_target_aligned     = {i_target[XLEN-1:2], 2'b00};
    assign w_unused_target_lsbs = &{1'b0, i_target[1:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc <= RESET_PC;
        end else if (i_redirect) begin
            r_pc <= w_target_aligned;
        end else if (i_advance) begin
            r_pc <= r_pc + PC_STEP;
        end
    end

    assign o_pc = r_pc;

endmodule
`default_nettype wire

// File: rtl/if_stage_regs.sv
`default_nettype none
//============================================================================
// Module   : if_stage_regs
// Desc     : Fetch stage: PC, IF/ID pipeline register, stall/flush counters.
// Revision : 1.0 - initial release
//============================================================================
module if_stage_regs
    import if_stage_regs_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             PCwrite,
    input  logic             IF_IDwrite,
    input  logic             PCSrc,
    input  logic [31:0]      branch_target,
    output logic [31:0]      imem_addr,
    input  logic [31:0]      imem_instr,
    output logic [31:0]      IF_ID_pc,
    output logic [31:0]      IF_ID_instr,
    output logic             IF_ID_valid,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

    logic [XLEN-1:0]  w_pc;
    logic             w_stall_event;
    if_id_t           r_if_id;
    logic [CNT_W-1:0] r_stall_count;
    logic [CNT_W-1:0] r_flush_count;

    if_stage_regs_pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk        (clk),
        .rst        (reset),
        .i_redirect (PCSrc),
        .i_target   (branch_target),
        .i_advance  (PCwrite),
        .o_pc       (w_pc)
    );

    // A redirect comes from an older instruction, so it outranks a load-use stall.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_if_id <= IF_ID_BUBBLE;
        end else if (PCSrc) begin
            r_if_id <= IF_ID_BUBBLE;
        end else if (IF_IDwrite) begin
            r_if_id <= make_if_id(w_pc, imem_instr);
        end
    end

    assign w_stall_event = !PCwrite && !PCSrc;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_count <= '0;
            r_flush_count <= '0;
        end else begin
            if (w_stall_event && (r_stall_count != c_cnt_max)) begin
                r_stall_count <= r_stall_count + c_cnt_one;
            end
            if (PCSrc && (r_flush_count != c_cnt_max)) begin
                r_flush_count <= r_flush_count + c_cnt_one;
            end
        end
    end

    assign imem_addr   = w_pc;
    assign IF_ID_pc    = r_if_id.pc;
    assign IF_ID_instr = r_if_id.instr;
    assign IF_ID_valid = r_if_id.valid;
    assign stall_count = r_stall_count;
    assign flush_count = r_flush_count;

endmodule
`default_nettype wire

// File: tb/tb_if_stage_regs.sv
`default_nettype none
//============================================================================
// Module   : tb_if_stage_regs
// Desc     : Self-checking bench for if_stage_regs against a cycle-level model.
// Revision : 1.0 - initial release
//============================================================================
module tb_if_stage_regs;

    localparam int          CNT_W    = 4;
    localparam int          CNT_MAX  = (1 << CNT_W) - 1;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic             clk = 1'b0;
    logic             reset;
    logic             PCwrite;
    logic             IF_IDwrite;
    logic             PCSrc;
    logic [31:0]      branch_target;
    logic [31:0]      imem_addr;
    logic [31:0]      imem_instr;
    logic [31:0]      IF_ID_pc;
    logic [31:0]      IF_ID_instr;
    logic             IF_ID_valid;
    logic [CNT_W-1:0] stall_count;
    logic [CNT_W-1:0] flush_count;

    logic [31:0] key = 32'hA5A5_0000;

    // Reference model state
    logic [31:0] m_pc;
    logic [31:0] m_ifpc;
    logic [31:0] m_ifinstr;
    logic        m_valid;
    int          m_stall;
    int          m_flush;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // Instruction memory stand-in: word contents derived from the address
    assign imem_instr = imem_addr ^ key;

    if_stage_regs #(
        .RESET_PC (RESET_PC),
        .CNT_W    (CNT_W)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .PCwrite       (PCwrite),
        .IF_IDwrite    (IF_IDwrite),
        .PCSrc         (PCSrc),
        .branch_target (branch_target),
        .imem_addr     (imem_addr),
        .imem_instr    (imem_instr),
        .IF_ID_pc      (IF_ID_pc),
        .IF_ID_instr   (IF_ID_instr),
        .IF_ID_valid   (IF_ID_valid),
        .stall_count   (stall_count),
        .flush_count   (flush_count)
    );

    logic [104:0] dut_vec;
    logic [104:0] exp_vec;
    logic [CNT_W-1:0] m_stall_v;
    logic [CNT_W-1:0] m_flush_v;
    assign m_stall_v = m_stall[CNT_W-1:0];
    assign m_flush_v = m_flush[CNT_W-1:0];
    assign dut_vec = {imem_addr, IF_ID_pc, IF_ID_instr, IF_ID_valid, stall_count, flush_count};
    assign exp_vec = {m_pc, m_ifpc, m_ifinstr, m_valid, m_stall_v, m_flush_v};

    // One clock edge: the model applies the architectural rules to the inputs
    // present at the edge, then outputs are sampled 1ns later.
    task automatic tick();
        logic [31:0] k;
        k = key;
        @(posedge clk);
        if (reset) begin
            m_pc = RESET_PC; m_ifpc = 32'd0; m_ifinstr = NOP; m_valid = 1'b0;
            m_stall = 0; m_flush = 0;
        end else if (PCSrc) begin
            m_pc = branch_target & 32'hFFFF_FFFC;
            m_ifpc = 32'd0; m_ifinstr = NOP; m_valid = 1'b0;
            if (m_flush < CNT_MAX) m_flush = m_flush + 1;
        end else begin
            if (IF_IDwrite) begin
                m_ifpc = m_pc; m_ifinstr = m_pc ^ k; m_valid = 1'b1;
            end
            if (!PCwrite) begin
                if (m_stall < CNT_MAX) m_stall = m_stall + 1;
            end else begin
                m_pc = m_pc + 32'd4;
            end
        end
        #1;
    endtask

    task automatic drive(input logic rst, input logic pcw, input logic ifw,
                         input logic src, input logic [31:0] tgt);
        reset = rst; PCwrite = pcw; IF_IDwrite = ifw; PCSrc = src; branch_target = tgt;
    endtask

    task automatic test_reset();
        drive(1'b1, 1'b1, 1'b1, 1'b0, 32'd0);
        tick();
        n_checks++;
        if (dut_vec !== exp_vec) begin
            n_fail++; $display("FAIL reset_state: got %h expected %h", dut_vec, exp_vec);
        end
        n_checks++;
        if ({imem_addr, IF_ID_valid, IF_ID_instr} !== {RESET_PC, 1'b0, NOP}) begin
            n_fail++; $display("FAIL reset_const: got pc=%h v=%b i=%h", imem_addr, IF_ID_valid, IF_ID_instr);
        end
    endtask

    task automatic test_free_run();
        drive(1'b1, 1'b1, 1'b1, 1'b0, 32'd0); tick();
        drive(1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++;
            if (dut_vec !== exp_vec) begin
                n_fail++; $display("FAIL free_run[%0d]: got %h expected %h", i, dut_vec, exp_vec);
            end
            n_checks++;
            if ({imem_addr, IF_ID_pc, IF_ID_instr, IF_ID_valid} !==
                {32'(4 * (i + 1)), 32'(4 * i), 32'(4 * i) ^ 32'hA5A5_0000, 1'b1}) begin
                n_fail++; $display("FAIL free_run_const[%0d]: got addr=%h ifpc=%h instr=%h v=%b",
                                   i, imem_addr, IF_ID_pc, IF_ID_instr, IF_ID_valid);
            end
        end
    endtask

    task automatic test_stall();
        drive(1'b1, 1'b1, 1'b1, 1'b0, 32'd0); tick();
        drive(1'b0, 1'b1, 1'b1, 1'b0, 32'd0); tick(); tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0); tick();
        n_checks++;
        if ({imem_addr, IF_ID_pc, stall_count} !== {32'h8, 32'h4, 4'd1}) begin
            n_fail++; $display("FAIL stall_hold: got addr=%h ifpc=%h stall=%0d expected 8/4/1",
                               imem_addr, IF_ID_pc, stall_count);
        end
        drive(1'b0, 1'b1, 1'b1, 1'b0, 32'd0); tick();
        n_checks++;
        if ({imem_addr, IF_ID_pc, IF_ID_instr} !== {32'hC, 32'h8, 32'h8 ^ 32'hA5A5_0000}) begin
            n_fail++; $display("FAIL stall_resume: got addr=%h ifpc=%h instr=%h", imem_addr, IF_ID_pc, IF_ID_instr);
        end
        // Independent controls: PC holds while IF/ID reloads, then the reverse
        drive(1'b0, 1'b0, 1'b1, 1'b0, 32'd0); tick();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 32'd0); tick();
        n_checks++;
        if (dut_vec !== exp_vec) begin
            n_fail++; $display("FAIL split_controls: got %h expected %h", dut_vec, exp_vec);
        end
    endtask

    task automatic test_redirect();
        drive(1'b1, 1'b1, 1'b1, 1'b0, 32'd0); tick();
        drive(1'b0, 1'b1, 1'b1, 1'b0, 32'd0); tick();
        drive(1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0103); tick();
        n_checks++;
        if ({imem_addr, IF_ID_instr, IF_ID_valid, flush_count, IF_ID_pc} !==
            {32'h100, NOP, 1'b0, 4'd1, 32'd0}) begin
            n_fail++; $display("FAIL redirect: got addr=%h instr=%h v=%b flush=%0d", imem_addr,
                               IF_ID_instr, IF_ID_valid, flush_count);
        end
        drive(1'b0, 1'b1, 1'b1, 1'b0, 32'd0); tick();
        n_checks++;
        if ({IF_ID_pc, IF_ID_valid, imem_addr} !== {32'h100, 1'b1, 32'h104}) begin
            n_fail++; $display("FAIL redirect_fill: got ifpc=%h v=%b addr=%h", IF_ID_pc, IF_ID_valid, imem_addr);
        end
    endtask

    task automatic test_flush_over_stall();
        logic [31:0] tgt;
        tgt = $urandom;
        drive(1'b0, 1'b0, 1'b0, 1'b1, tgt); tick();
        n_checks++;
        if (dut_vec !== exp_vec) begin
            n_fail++; $display("FAIL flush_over_stall: got %h expected %h", dut_vec, exp_vec);
        end
        n_checks++;
        if ({imem_addr, stall_count, IF_ID_valid} !== {tgt & 32'hFFFF_FFFC, 4'd0, 1'b0}) begin
            n_fail++; $display("FAIL flush_over_stall_const: got addr=%h stall=%0d v=%b", imem_addr, stall_count, IF_ID_valid);
        end
    endtask

    task automatic test_wrap_sat();
        drive(1'b0, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF); tick();
        drive(1'b0, 1'b1, 1'b1, 1'b0, 32'd0); tick();
        n_checks++;
        if ({imem_addr, IF_ID_pc} !== {32'h0, 32'hFFFF_FFFC}) begin
            n_fail++; $display("FAIL pc_wrap: got addr=%h ifpc=%h expected 0/fffffffc", imem_addr, IF_ID_pc);
        end
        drive(1'b1, 1'b1, 1'b1, 1'b0, 32'd0); tick();
        drive(1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
        for (int i = 0; i < 20; i++) begin
            tick();
            n_checks++;
            if ((dut_vec !== exp_vec) || (stall_count !== CNT_W'((i < CNT_MAX) ? i + 1 : CNT_MAX))) begin
                n_fail++; $display("FAIL stall_sat[%0d]: got %h expected %h", i, dut_vec, exp_vec);
            end
        end
        drive(1'b0, 1'b1, 1'b1, 1'b1, 32'h40);
        for (int i = 0; i < 18; i++) tick();
        n_checks++;
        if (flush_count !== 4'hF) begin
            n_fail++; $display("FAIL flush_sat: got %0d expected 15", flush_count);
        end
    endtask

    task automatic test_reset_mid_stall();
        drive(1'b0, 1'b1, 1'b1, 1'b0, 32'd0); tick(); tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0); tick();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'd0); tick();
        n_checks++;
        if ({imem_addr, IF_ID_valid, stall_count, flush_count} !== {RESET_PC, 1'b0, 4'd0, 4'd0}) begin
            n_fail++; $display("FAIL reset_mid_stall: got addr=%h v=%b stall=%0d flush=%0d",
                               imem_addr, IF_ID_valid, stall_count, flush_count);
        end
        drive(1'b0, 1'b1, 1'b1, 1'b0, 32'd0); tick();
        n_checks++;
        if ({IF_ID_pc, IF_ID_valid} !== {RESET_PC, 1'b1}) begin
            n_fail++; $display("FAIL first_fetch_after_reset: got ifpc=%h v=%b", IF_ID_pc, IF_ID_valid);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, $urandom);
            tick();
            n_checks++;
            if (dut_vec !== exp_vec) begin
                n_fail++; $display("FAIL random[%0d]: got %h expected %h", i, dut_vec, exp_vec);
            end
            key = $urandom;
        end
    endtask

    initial begin
        drive(1'b1, 1'b1, 1'b1, 1'b0, 32'd0);
        m_pc = '0; m_ifpc = '0; m_ifinstr = NOP; m_valid = 1'b0; m_stall = 0; m_flush = 0;
        test_reset();
        test_free_run();
        test_stall();
        test_redirect();
        test_flush_over_stall();
        test_wrap_sat();
        test_reset_mid_stall();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
